// File: rtl/mcycle_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine, one result bit per cycle.
// Optional macro MCYCLE_EARLY_EXIT_EN: zero-operand multiply and divide-by-zero finish without COMPUTE.
module mcycle_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic             op;
  logic [WIDTH-1:0] hi, lo, opnd;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   sum_c, diff_c, trial_c;
  logic             accept_c, last_c, early_c, ge_c;

  assign accept_c = Start && (state != COMPUTE);
  assign last_c   = (state == COMPUTE) && (count == CW'(WIDTH - 1));
  assign Busy     = (state == COMPUTE) || accept_c;

`ifdef MCYCLE_EARLY_EXIT_EN
  assign early_c = MCycleOp ? (Operand2 == '0) : ((Operand1 == '0) || (Operand2 == '0));
`else
  assign early_c = 1'b0;
`endif

  // One iteration: hi/lo hold {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    hi_nxt  = hi;
    lo_nxt  = lo;
    sum_c   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    trial_c = {hi, lo[WIDTH-1]};
    ge_c    = trial_c >= {1'b0, opnd};
    diff_c  = trial_c - {1'b0, opnd};
    if (op) begin
      hi_nxt = ge_c ? diff_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], ge_c};
    end else begin
      hi_nxt = sum_c[WIDTH:1];
      lo_nxt = {sum_c[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (Start)             state_nxt = early_c ? DONE : COMPUTE;
        else if (state == DONE) state_nxt = IDLE;
      end
      COMPUTE: if (last_c) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration registers and result capture
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count   <= '0;
      op      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
      Result1 <= '0;
      Result2 <= '0;
      Done    <= 1'b0;
    end else begin
      Done <= (state_nxt == DONE);
      if (accept_c) begin
        count <= '0;
        op    <= MCycleOp;
        hi    <= '0;
        lo    <= MCycleOp ? Operand1 : Operand2;
        opnd  <= MCycleOp ? Operand2 : Operand1;
        if (early_c) begin
          Result1 <= MCycleOp ? '1 : '0;
          Result2 <= MCycleOp ? Operand1 : '0;
        end
      end else if (state == COMPUTE) begin
        hi    <= hi_nxt;
        lo    <= lo_nxt;
        count <= last_c ? '0 : count + CW'(1);
        if (last_c) begin
          Result1 <= lo_nxt;
          Result2 <= hi_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit: vector table plus back-to-back, ignored-start and mid-op reset sequences.
module tb_mcycle_unit;

  localparam int unsigned WIDTH = 32;
  localparam int FLAT = 33;
`ifdef MCYCLE_EARLY_EXIT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r1;
    logic [31:0] r2;
    int          lat;
  } vec_t;

  logic        CLK, Reset, Start, MCycleOp, Busy, Done;
  logic [31:0] Operand1, Operand2, Result1, Result2;
  logic [31:0] last1, last2;
  int          vecs, errs;
  vec_t        tbl[14];

  mcycle_unit #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive a request at a negedge; returns at the negedge of cycle 1
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b, input string tag);
    MCycleOp = op; Operand1 = a; Operand2 = b; Start = 1'b1;
    #1 check({tag, " busy_start"}, 32'(Busy), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom; MCycleOp = 1'($urandom);
  endtask

  // Wait for Done (bounded); optionally pulse Start in cycle inject_at
  task automatic wait_done(input int lat, input logic [31:0] e1, input logic [31:0] e2,
                           input int inject_at, input string tag);
    int c = 1;
    bit busy_bad = 0, hold_bad = 0;
    while (Done !== 1'b1 && c < 100) begin
      if (Busy !== 1'b1) busy_bad = 1;
      if (Result1 !== last1 || Result2 !== last2) hold_bad = 1;
      Start = (c == inject_at);
      if (Start) begin Operand1 = 32'h55; Operand2 = 32'h3; MCycleOp = 1'b1; end
      @(posedge CLK);
      c++;
      @(negedge CLK);
    end
    Start = 1'b0;
    check({tag, " busy_compute"}, 32'(busy_bad), 32'd0);
    check({tag, " result_hold"}, 32'(hold_bad), 32'd0);
    check({tag, " done_cycle"}, 32'(c), 32'(lat));
    check({tag, " done_busy"}, 32'(Busy), 32'd0);
    check({tag, " result1"}, Result1, e1);
    check({tag, " result2"}, Result2, e2);
    last1 = e1;
    last2 = e2;
  endtask

  task automatic idle_check(input string tag);
    @(negedge CLK);
    check({tag, " idle_done"}, 32'(Done), 32'd0);
    check({tag, " idle_busy"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    vecs = 0; errs = 0; last1 = '0; last2 = '0;
    Reset = 1'b1; Start = 1'b0; MCycleOp = 1'b0; Operand1 = '0; Operand2 = '0;

    tbl[0]  = '{1'b0, 32'd7,          32'd6,          32'h0000002A, 32'h00000000, FLAT};
    tbl[1]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 32'hFFFFFFFE, FLAT};
    tbl[2]  = '{1'b1, 32'd100,        32'd7,          32'd14,       32'd2,        FLAT};
    tbl[3]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF, 32'd5,        ZLAT};
    tbl[4]  = '{1'b0, 32'h00010000,   32'h00010000,   32'h00000000, 32'h00000001, FLAT};
    tbl[5]  = '{1'b1, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'd0,        FLAT};
    tbl[6]  = '{1'b1, 32'd3,          32'd10,         32'd0,        32'd3,        FLAT};
    tbl[7]  = '{1'b0, 32'd0,          32'h00001234,   32'd0,        32'd0,        ZLAT};
    tbl[8]  = '{1'b0, 32'h80000000,   32'd2,          32'h00000000, 32'h00000001, FLAT};
    tbl[9]  = '{1'b1, 32'h80000000,   32'h80000000,   32'd1,        32'd0,        FLAT};
    tbl[10] = '{1'b1, 32'hDEADBEEF,   32'h00010000,   32'h0000DEAD, 32'h0000BEEF, FLAT};
    tbl[11] = '{1'b0, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE, 32'h00000001, FLAT};
    tbl[12] = '{1'b1, 32'd0,          32'd0,          32'hFFFFFFFF, 32'd0,        ZLAT};
    tbl[13] = '{1'b0, 32'h00012345,   32'h00000010,   32'h00123450, 32'd0,        FLAT};

    repeat (2) @(negedge CLK);
    check("reset result1", Result1, 32'd0);
    check("reset result2", Result2, 32'd0);
    check("reset done", 32'(Done), 32'd0);
    check("reset busy", 32'(Busy), 32'd0);
    Reset = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 14; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, $sformatf("vec%0d", i));
      wait_done(tbl[i].lat, tbl[i].r1, tbl[i].r2, -1, $sformatf("vec%0d", i));
      idle_check($sformatf("vec%0d", i));
    end

    // Back-to-back: new Start in the DONE cycle
    issue(1'b1, 32'd100, 32'd7, "b2b_first");
    wait_done(FLAT, 32'd14, 32'd2, -1, "b2b_first");
    issue(1'b1, 32'hFFFFFFFF, 32'h10, "b2b_second");
    wait_done(FLAT, 32'h0FFFFFFF, 32'hF, -1, "b2b_second");
    idle_check("b2b");

    // Start during COMPUTE must be ignored
    issue(1'b0, 32'h1234, 32'h100, "ignore");
    wait_done(FLAT, 32'h00123400, 32'd0, 10, "ignore");
    repeat (3) idle_check("ignore_after");

    // Reset in cycle 15 of a divide
    issue(1'b1, 32'd1000, 32'd3, "mid_reset");
    repeat (14) @(negedge CLK);
    Reset = 1'b1;
    #1;
    check("mid_reset busy", 32'(Busy), 32'd0);
    check("mid_reset done", 32'(Done), 32'd0);
    check("mid_reset result1", Result1, 32'd0);
    check("mid_reset result2", Result2, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    last1 = '0; last2 = '0;
    begin
      bit done_seen = 0, busy_seen = 0;
      repeat (40) begin
        @(negedge CLK);
        if (Done !== 1'b0) done_seen = 1;
        if (Busy !== 1'b0) busy_seen = 1;
      end
      check("mid_reset no_done", 32'(done_seen), 32'd0);
      check("mid_reset no_busy", 32'(busy_seen), 32'd0);
    end
    issue(1'b0, 32'd3, 32'd4, "post_reset");
    wait_done(FLAT, 32'd12, 32'd0, -1, "post_reset");
    idle_check("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Multi-cycle unsigned multiply/divide engine sitting directly downstream of the pipelined control unit in the Execute stage.
- Consumes the start pulse, operation select and operands issued in Execute.
- Returns a 2-word result plus Busy/Done so the hazard logic can stall the pipeline and write-back can take the result.
- Iterative, one result bit per cycle. Shift-add for multiply, restoring division for divide.

Parameters:
WIDTH, 32, operand/result word width in bits (>=4)

Ports:
CLK  input  1  clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  request a new operation; sampled only when not in COMPUTE
MCycleOp  input  1  0 = unsigned multiply, 1 = unsigned divide
Operand1  input  WIDTH  multiplicand / dividend
Operand2  input  WIDTH  multiplier / divisor
Result1  output  WIDTH  multiply: product[WIDTH-1:0]; divide: quotient
Result2  output  WIDTH  multiply: product[2*WIDTH-1:WIDTH]; divide: remainder
Busy  output  1  operation in progress (stall request)
Done  output  1  one-cycle pulse, results valid

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, counter=0.
  - Result1=0, Result2=0, Done=0, Busy=0 (Busy still follows Start combinationally, see below).
  - In-flight operation is discarded and produces no Done.
- States:
  - IDLE: Start=1 latches Operand1, Operand2 and MCycleOp, clears the accumulator, counter=0, then goes to COMPUTE.
  - COMPUTE: one iteration per cycle, counter increments. When counter==WIDTH-1 the final iteration completes and the block goes to DONE.
  - DONE: lasts one cycle with Done=1. Start=1 here is accepted exactly as in IDLE and goes to COMPUTE. Otherwise the block goes to IDLE.
- Timing: Start sampled at edge 0. Cycles 1..WIDTH are COMPUTE. Cycle WIDTH+1 is DONE. Fixed latency of WIDTH+1 cycles.
- Busy = (state==COMPUTE) | (Start & state!=COMPUTE).
  - This is combinational, so the hazard unit stalls in the same cycle as Start.
  - Busy=0 in the DONE cycle unless a new Start is present.
- Start while in COMPUTE is ignored. Latched operands are unaffected by input changes after acceptance.
- Operand inputs are don't-care except in the Start-accept cycle.
- Multiply:
  - 2*WIDTH accumulator; each iteration adds the shifted multiplicand if the current multiplier bit is 1.
  - Result is the full unsigned 2*WIDTH product; no overflow flag.
- Divide (restoring):
  - Each iteration shifts the remainder left 1, brings in the next dividend bit, and trial-subtracts the divisor (WIDTH+1-bit compare).
  - Quotient bit = 1 if the difference is non-negative.
  - Divisor==0: Result1 = all ones and Result2 = Operand1. This falls out of restoring division and must be exact.
- Result1/Result2:
  - Registered; update only on the COMPUTE->DONE edge.
  - Hold until the next completion. Partial results are never visible.
- Done is high only in the DONE state.

Optional Feature:
- MCYCLE_EARLY_EXIT_EN defined:
  - Multiply with Operand1==0 or Operand2==0 skips COMPUTE: accept goes straight to DONE with Result1=Result2=0, latency 1 cycle.
  - Divide with Operand2==0 goes straight to DONE with Result1=all ones and Result2=Operand1.
  - Busy is high only in the Start cycle.
- Not defined: every operation takes the fixed WIDTH+1 cycles, including zero operands.

Test Plan:
- Reset, then Start with MCycleOp=0, 7 x 6 -> Busy high in cycles 0..32, Done pulse in cycle 33 only, Result1=0x0000002A, Result2=0x00000000.
- MCycleOp=0, 0xFFFFFFFF x 0xFFFFFFFF -> Result1=0x00000001, Result2=0xFFFFFFFE at Done; previous results held until then.
- MCycleOp=1, 100 / 7 -> Result1=14, Result2=2. Back-to-back Start in the DONE cycle with 0xFFFFFFFF / 0x10 -> second Done 33 cycles later, Result1=0x0FFFFFFF, Result2=0xF.
- MCycleOp=1, 5 / 0 -> Result1=0xFFFFFFFF, Result2=5. With MCYCLE_EARLY_EXIT_EN, Done in cycle 1; without it, Done in cycle 33.
- Start pulse in cycle 10 of a running multiply with different operands -> ignored; original product returned in cycle 33 and no second Done.
- Reset asserted in cycle 15 of a divide -> Busy=0, Done never pulses, Result1/Result2=0. New 3 x 4 after release -> Result1=12.
